bist_fail_logger: RTL and testbench

- Downstream consumer of the SRAM BIST read-compare stage.
- Takes each compare event (address, pattern phase, expected, actual), detects mismatches, and buffers failing entries in a small FIFO log.
- Keeps a saturating fail count, a sticky overflow flag and first-fail capture registers.
- Diagnostic software or a scan/debug port drains the log through a valid/ready interface after or during a test run.

---
 rtl/bist_fail_logger.sv | 156 +++++++++++++++
 tb/tb_bist_fail_logger.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_fail_logger.sv
// BIST fail logger: detects read-compare mismatches, buffers them in a small FIFO log,
// and keeps a saturating fail count, sticky overflow flag and first-fail address.
module bist_fail_logger #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 3,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_start,
    input  logic               test_active,
    input  logic               cmp_valid,
    input  logic [ADDR_W-1:0]  cmp_addr,
    input  logic [PHASE_W-1:0] cmp_phase,
    input  logic [DATA_W-1:0]  cmp_exp,
    input  logic [DATA_W-1:0]  cmp_act,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [PHASE_W-1:0] rd_phase,
    output logic [DATA_W-1:0]  rd_syndrome,
    output logic [CNT_W-1:0]   fail_count,
    output logic               log_overflow,
    output logic               first_fail_valid,
    output logic [ADDR_W-1:0]  first_fail_addr,
    output logic               done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state_reg, state_next;

    logic               seen_active_reg;
    logic [ADDR_W-1:0]  mem_addr [DEPTH];
    logic [PHASE_W-1:0] mem_phase [DEPTH];
    logic [DATA_W-1:0]  mem_syn [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]     count_reg, count_next;
    logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
    logic [PHASE_W-1:0] rd_phase_reg, rd_phase_next;
    logic [DATA_W-1:0]  rd_syn_reg, rd_syn_next;
    logic [CNT_W-1:0]   fail_count_reg;
    logic               overflow_reg, ff_valid_reg;
    logic [ADDR_W-1:0]  ff_addr_reg;

    logic mismatch, pop, full, push, drop;
    logic [DATA_W-1:0] syndrome;

    // test_start wins over any same-cycle compare or pop: the log is wiped anyway.
    assign syndrome = cmp_exp ^ cmp_act;
    assign mismatch = (state_reg == ARMED) && cmp_valid && test_active
                      && (cmp_exp != cmp_act) && !test_start;
    assign pop      = (count_reg != '0) && rd_ready && !test_start;
    assign full     = (count_reg == FULL_CNT);
    assign push     = mismatch && (!full || pop);
    assign drop     = mismatch && full && !pop;

    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    assign count_next  = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // Head registers preload the next head entry; the entry being written bypasses the array.
    always_comb begin
        rd_addr_next  = mem_addr[rd_ptr_next];
        rd_phase_next = mem_phase[rd_ptr_next];
        rd_syn_next   = mem_syn[rd_ptr_next];
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            rd_addr_next  = cmp_addr;
            rd_phase_next = cmp_phase;
            rd_syn_next   = syndrome;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_log_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_addr[gi]  <= cmp_addr;
                    mem_phase[gi] <= cmp_phase;
                    mem_syn[gi]   <= syndrome;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (test_start) begin
            state_next = ARMED;
        end else begin
            case (state_reg)
                ARMED:   if (seen_active_reg && !test_active) state_next = DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst || test_start) begin
            seen_active_reg <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            fail_count_reg  <= '0;
            overflow_reg    <= 1'b0;
            ff_valid_reg    <= 1'b0;
            ff_addr_reg     <= '0;
        end else begin
            if (state_reg == ARMED && test_active) seen_active_reg <= 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (mismatch && (fail_count_reg != '1)) fail_count_reg <= fail_count_reg + CNT_W'(1);
            if (drop) overflow_reg <= 1'b1;
            if (mismatch && !ff_valid_reg) begin
                ff_valid_reg <= 1'b1;
                ff_addr_reg  <= cmp_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg  <= '0;
            rd_phase_reg <= '0;
            rd_syn_reg   <= '0;
        end else if (!test_start && (count_next != '0)) begin
            rd_addr_reg  <= rd_addr_next;
            rd_phase_reg <= rd_phase_next;
            rd_syn_reg   <= rd_syn_next;
        end
    end

    assign rd_valid         = (count_reg != '0);
    assign rd_addr          = rd_addr_reg;
    assign rd_phase         = rd_phase_reg;
    assign rd_syndrome      = rd_syn_reg;
    assign fail_count       = fail_count_reg;
    assign log_overflow     = overflow_reg;
    assign first_fail_valid = ff_valid_reg;
    assign first_fail_addr  = ff_addr_reg;
endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger; a second instance with a 3-bit counter covers saturation.
module tb_bist_fail_logger;
    logic       clk = 1'b0;
    logic       rst, test_start, test_active, cmp_valid, rd_ready;
    logic [5:0] cmp_addr;
    logic [2:0] cmp_phase;
    logic [7:0] cmp_exp, cmp_act;

    logic       rd_valid, log_overflow, first_fail_valid, done;
    logic [5:0] rd_addr, first_fail_addr;
    logic [2:0] rd_phase;
    logic [7:0] rd_syndrome, fail_count;

    logic       s_rd_valid, s_overflow, s_ff_valid, s_done;
    logic [5:0] s_rd_addr, s_ff_addr;
    logic [2:0] s_rd_phase, s_fail_count;
    logic [7:0] s_rd_syndrome;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bist_fail_logger dut (
        .clk(clk), .rst(rst), .test_start(test_start), .test_active(test_active),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_phase(cmp_phase),
        .cmp_exp(cmp_exp), .cmp_act(cmp_act), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_phase(rd_phase),
        .rd_syndrome(rd_syndrome), .fail_count(fail_count), .log_overflow(log_overflow),
        .first_fail_valid(first_fail_valid), .first_fail_addr(first_fail_addr), .done(done)
    );

    bist_fail_logger #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .test_start(test_start), .test_active(test_active),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_phase(cmp_phase),
        .cmp_exp(cmp_exp), .cmp_act(cmp_act), .rd_ready(rd_ready),
        .rd_valid(s_rd_valid), .rd_addr(s_rd_addr), .rd_phase(s_rd_phase),
        .rd_syndrome(s_rd_syndrome), .fail_count(s_fail_count), .log_overflow(s_overflow),
        .first_fail_valid(s_ff_valid), .first_fail_addr(s_ff_addr), .done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        test_start = 0; cmp_valid = 0; rd_ready = 0;
        cmp_addr = 0; cmp_phase = 0; cmp_exp = 0; cmp_act = 0;
    endtask

    task automatic arm();
        idle_inputs();
        test_start = 1; test_active = 1;
        tick();
        test_start = 0;
    endtask

    task automatic mismatch_at(input logic [5:0] a);
        cmp_valid = 1; cmp_addr = a; cmp_phase = 3'd1; cmp_exp = 8'hFF; cmp_act = 8'h0F;
        tick();
        cmp_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); test_active = 0; rst = 1;
        tick(); tick();
        rst = 0;
        n_tests++;
        if ({rd_valid, rd_addr, rd_phase, rd_syndrome, fail_count, log_overflow,
             first_fail_valid, first_fail_addr, done} !== '0) begin
            $display("FAIL reset: outputs=%0h required 0", {rd_valid, rd_addr, rd_phase,
                     rd_syndrome, fail_count, log_overflow, first_fail_valid, first_fail_addr, done});
            n_fail++;
        end
        // compares in IDLE are ignored
        test_active = 1;
        mismatch_at(6'h11);
        n_tests++;
        if (fail_count !== 8'd0 || rd_valid !== 1'b0) begin
            $display("FAIL idle_ignore: fail_count=%0d rd_valid=%0b required 0 0", fail_count, rd_valid);
            n_fail++;
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_run();
        arm();
        for (int i = 0; i < 64; i++) begin
            cmp_valid = 1; cmp_addr = 6'(i); cmp_exp = 8'(i * 3); cmp_act = 8'(i * 3);
            tick();
        end
        cmp_valid = 0; test_active = 0;
        n_tests++;
        if (done !== 1'b0) begin
            $display("FAIL done_early: done=%0b required 0", done); n_fail++;
        end
        tick();
        n_tests++;
        if (fail_count !== 8'd0 || rd_valid !== 1'b0 || first_fail_valid !== 1'b0 || done !== 1'b1) begin
            $display("FAIL clean_run: cnt=%0d rv=%0b ffv=%0b done=%0b required 0 0 0 1",
                     fail_count, rd_valid, first_fail_valid, done);
            n_fail++;
        end
        // compares in DONE are ignored even with test_active high
        test_active = 1;
        mismatch_at(6'h22);
        n_tests++;
        if (fail_count !== 8'd0 || done !== 1'b1) begin
            $display("FAIL done_ignore: cnt=%0d done=%0b required 0 1", fail_count, done); n_fail++;
        end
        $display("[TB] test_clean_run done");
    endtask

    task automatic test_single_fail();
        arm();
        cmp_valid = 1; cmp_addr = 6'h2A; cmp_phase = 3'd3; cmp_exp = 8'h55; cmp_act = 8'h51;
        tick();
        cmp_valid = 0;
        n_tests++;
        if (rd_valid !== 1'b1 || rd_addr !== 6'h2A || rd_phase !== 3'd3 || rd_syndrome !== 8'h04 ||
            fail_count !== 8'd1 || first_fail_valid !== 1'b1 || first_fail_addr !== 6'h2A) begin
            $display("FAIL single_fail: rv=%0b addr=%0h ph=%0d syn=%0h cnt=%0d ffv=%0b ffa=%0h required 1 2a 3 04 1 1 2a",
                     rd_valid, rd_addr, rd_phase, rd_syndrome, fail_count, first_fail_valid, first_fail_addr);
            n_fail++;
        end
        tick();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_addr !== 6'h2A) begin
            $display("FAIL head_stable: rv=%0b addr=%0h required 1 2a", rd_valid, rd_addr); n_fail++;
        end
        $display("[TB] test_single_fail done");
    endtask

    task automatic test_overflow();
        arm();
        for (int a = 1; a <= 6; a++) mismatch_at(6'(a));
        n_tests++;
        if (fail_count !== 8'd6 || log_overflow !== 1'b1 || first_fail_addr !== 6'd1) begin
            $display("FAIL overflow: cnt=%0d ovf=%0b ffa=%0d required 6 1 1", fail_count, log_overflow, first_fail_addr);
            n_fail++;
        end
        rd_ready = 1;
        for (int a = 1; a <= 4; a++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_addr !== 6'(a)) begin
                $display("FAIL drain_%0d: rv=%0b addr=%0d required 1 %0d", a, rd_valid, rd_addr, a); n_fail++;
            end
            tick();
        end
        n_tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL drain_empty: rv=%0b required 0", rd_valid); n_fail++;
        end
        rd_ready = 0;
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_push_pop();
        logic [5:0] exp_order [4];
        exp_order = '{6'd2, 6'd3, 6'd4, 6'd9};
        arm();
        for (int a = 1; a <= 4; a++) mismatch_at(6'(a));
        rd_ready = 1;
        mismatch_at(6'd9);
        rd_ready = 0;
        n_tests++;
        if (log_overflow !== 1'b0 || fail_count !== 8'd5 || rd_addr !== 6'd2) begin
            $display("FAIL full_push_pop: ovf=%0b cnt=%0d head=%0d required 0 5 2", log_overflow, fail_count, rd_addr);
            n_fail++;
        end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_order[i]) begin
                $display("FAIL order_%0d: rv=%0b addr=%0d required 1 %0d", i, rd_valid, rd_addr, exp_order[i]);
                n_fail++;
            end
            tick();
        end
        n_tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL order_empty: rv=%0b required 0", rd_valid); n_fail++;
        end
        rd_ready = 0;
        $display("[TB] test_full_push_pop done");
    endtask

    task automatic test_saturate();
        arm();
        for (int a = 0; a < 10; a++) mismatch_at(6'(a + 20));
        n_tests++;
        if (s_fail_count !== 3'd7 || fail_count !== 8'd10) begin
            $display("FAIL saturate: small=%0d wide=%0d required 7 10", s_fail_count, fail_count); n_fail++;
        end
        mismatch_at(6'd40);
        n_tests++;
        if (s_fail_count !== 3'd7 || s_ff_addr !== 6'd20) begin
            $display("FAIL saturate_hold: small=%0d ffa=%0d required 7 20", s_fail_count, s_ff_addr); n_fail++;
        end
        $display("[TB] test_saturate done");
    endtask

    task automatic test_rearm_collision();
        arm();
        mismatch_at(6'd5);
        mismatch_at(6'd6);
        test_start = 1;
        cmp_valid = 1; cmp_addr = 6'd7; cmp_exp = 8'hAA; cmp_act = 8'h00;
        tick();
        test_start = 0; cmp_valid = 0;
        n_tests++;
        if (fail_count !== 8'd0 || rd_valid !== 1'b0 || log_overflow !== 1'b0 ||
            first_fail_valid !== 1'b0 || first_fail_addr !== 6'd0 || done !== 1'b0) begin
            $display("FAIL rearm: cnt=%0d rv=%0b ovf=%0b ffv=%0b ffa=%0d done=%0b required all 0",
                     fail_count, rd_valid, log_overflow, first_fail_valid, first_fail_addr, done);
            n_fail++;
        end
        mismatch_at(6'd12);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_addr !== 6'd12 || fail_count !== 8'd1 || first_fail_addr !== 6'd12) begin
            $display("FAIL rearm_armed: rv=%0b addr=%0d cnt=%0d ffa=%0d required 1 12 1 12",
                     rd_valid, rd_addr, fail_count, first_fail_addr);
            n_fail++;
        end
        $display("[TB] test_rearm_collision done");
    endtask

    initial begin
        rst = 1; test_active = 0;
        idle_inputs();
        test_reset();
        test_clean_run();
        test_single_fail();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_rearm_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
